// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, loader-written instruction memory,
// and the IF/ID register with branch/jump/halt next-PC selection.
module instruction_fetch #(
  parameter int INST_SZ   = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SZ   = $clog2(MEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_stall_HD,
  input  logic               i_pc_src_D,
  input  logic [INST_SZ-1:0] i_branch_addr_D,
  input  logic               i_jump_MC,
  input  logic               i_jump_sel_MC,
  input  logic [INST_SZ-1:0] i_jump_addr_D,
  input  logic [INST_SZ-1:0] i_rs_data_D,
  input  logic               i_halt_MC,
  input  logic               i_wr_en,
  input  logic [ADDR_SZ-1:0] i_wr_addr,
  input  logic [INST_SZ-1:0] i_wr_data,
  output logic [INST_SZ-1:0] o_instruction_D,
  output logic [INST_SZ-1:0] o_npc_D,
  output logic [INST_SZ-1:0] o_pc,
  output logic               o_halted
);

  logic [INST_SZ-1:0] imem [MEM_DEPTH];

  logic [INST_SZ-1:0] pc_q, pc_d;
  logic [INST_SZ-1:0] instr_q, instr_d;
  logic [INST_SZ-1:0] npc_q, npc_d;
  logic               halted_q, halted_d;

  logic               adv;
  logic [INST_SZ-1:0] pc_plus4;
  logic [ADDR_SZ-1:0] fetch_idx;
  logic [INST_SZ-1:0] fetch_word;

  assign adv        = i_enable & ~i_stall_HD & ~halted_q;
  assign pc_plus4   = pc_q + INST_SZ'(4);
  assign fetch_idx  = pc_q[ADDR_SZ+1:2];
  assign fetch_word = imem[fetch_idx];

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    halted_d = halted_q;
    if (halted_q) begin
      // keep feeding NOPs so the pipeline drains
      if (i_enable) instr_d = '0;
    end else if (adv) begin
      if (i_halt_MC) begin
        halted_d = 1'b1;
        instr_d  = '0;
      end else begin
        instr_d = fetch_word;
        npc_d   = pc_plus4;
        if (i_jump_MC)
          pc_d = i_jump_sel_MC ? i_rs_data_D : i_jump_addr_D;
        else if (i_pc_src_D)
          pc_d = i_branch_addr_D;
        else
          pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q     <= '0;
      instr_q  <= '0;
      npc_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      npc_q    <= npc_d;
      halted_q <= halted_d;
    end
  end

  // no reset on the array so a loaded program survives reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) imem[i_wr_addr] <= i_wr_data;
  end

  assign o_instruction_D = instr_q;
  assign o_npc_D         = npc_q;
  assign o_pc            = pc_q;
  assign o_halted        = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random stimulus,
// every cycle compared against a behavioural fetch model.
module tb_instruction_fetch;

  localparam int W = 32;
  localparam int D = 256;
  localparam int A = 8;

  logic         i_clk = 1'b0;
  logic         i_reset, i_enable, i_stall_HD, i_pc_src_D;
  logic [W-1:0] i_branch_addr_D, i_jump_addr_D, i_rs_data_D;
  logic         i_jump_MC, i_jump_sel_MC, i_halt_MC, i_wr_en;
  logic [A-1:0] i_wr_addr;
  logic [W-1:0] i_wr_data;
  logic [W-1:0] o_instruction_D, o_npc_D, o_pc;
  logic         o_halted;

  int n_chk  = 0;
  int n_fail = 0;

  bit [W-1:0] m_mem [D];
  bit [W-1:0] m_pc, m_ins, m_npc;
  bit         m_h;

  always #5 i_clk = ~i_clk;

  instruction_fetch #(.INST_SZ(W), .MEM_DEPTH(D), .ADDR_SZ(A)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_stall_HD(i_stall_HD), .i_pc_src_D(i_pc_src_D),
    .i_branch_addr_D(i_branch_addr_D), .i_jump_MC(i_jump_MC),
    .i_jump_sel_MC(i_jump_sel_MC), .i_jump_addr_D(i_jump_addr_D),
    .i_rs_data_D(i_rs_data_D), .i_halt_MC(i_halt_MC),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_instruction_D(o_instruction_D), .o_npc_D(o_npc_D),
    .o_pc(o_pc), .o_halted(o_halted)
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    i_reset = 0; i_enable = 1; i_stall_HD = 0; i_pc_src_D = 0;
    i_jump_MC = 0; i_jump_sel_MC = 0; i_halt_MC = 0; i_wr_en = 0;
    i_branch_addr_D = 0; i_jump_addr_D = 0; i_rs_data_D = 0;
    i_wr_addr = 0; i_wr_data = 0;
  endtask

  // Reference: one clock of fetch behaviour from the current inputs
  task automatic model();
    bit [W-1:0] word;
    word = m_mem[(m_pc / 4) % D];
    if (i_reset) begin
      m_pc = 0; m_ins = 0; m_npc = 0; m_h = 0;
    end else if (m_h) begin
      if (i_enable) m_ins = 0;
    end else if (i_enable && !i_stall_HD) begin
      if (i_halt_MC) begin
        m_h = 1; m_ins = 0;
      end else begin
        m_ins = word;
        m_npc = m_pc + 4;
        if (i_jump_MC) m_pc = i_jump_sel_MC ? i_rs_data_D : i_jump_addr_D;
        else if (i_pc_src_D) m_pc = i_branch_addr_D;
        else m_pc = m_pc + 4;
      end
    end
    if (i_wr_en) m_mem[i_wr_addr] = i_wr_data;
  endtask

  task automatic step();
    model();
    @(posedge i_clk);
    #1;
    chk("pc", o_pc, m_pc);
    chk("instr", o_instruction_D, m_ins);
    chk("npc", o_npc_D, m_npc);
    chk("halted", {31'b0, o_halted}, {31'b0, m_h});
  endtask

  task automatic rst_pulse();
    idle(); i_reset = 1; step(); i_reset = 0;
  endtask

  initial begin
    idle();
    i_reset = 1;
    #1;
    for (int k = 0; k < D; k++) begin
      i_wr_en = 1; i_wr_addr = A'(k);
      i_wr_data = (k < 4) ? W'(32'h11 * (k + 1)) : $urandom;
      step();
    end
    chk("rst_pc", o_pc, 0);
    chk("rst_instr", o_instruction_D, 0);
    idle();

    // sequential fetch
    step(); chk("seq0", o_instruction_D, 32'h11); chk("npc0", o_npc_D, 4);
    step(); chk("seq1", o_instruction_D, 32'h22); chk("npc1", o_npc_D, 8);
    i_stall_HD = 1; step(); step();
    chk("stall_pc", o_pc, 8); chk("stall_ins", o_instruction_D, 32'h22);
    i_stall_HD = 0; step();
    chk("seq2", o_instruction_D, 32'h33); chk("npc2", o_npc_D, 12);

    // branch with delay slot, then jump beating branch
    rst_pulse(); step();
    i_pc_src_D = 1; i_branch_addr_D = 32'h40; step();
    chk("br_pc", o_pc, 32'h40); chk("br_slot", o_instruction_D, 32'h22);
    rst_pulse(); step();
    i_pc_src_D = 1; i_branch_addr_D = 32'h40;
    i_jump_MC = 1; i_jump_addr_D = 32'h80; step();
    chk("jmp_pc", o_pc, 32'h80);

    // register jump and wrap at the top of memory
    idle(); i_jump_MC = 1; i_jump_sel_MC = 1; i_rs_data_D = 32'h3FC; step();
    chk("jr_pc", o_pc, 32'h3FC);
    idle(); step();
    chk("top_ins", o_instruction_D, m_mem[255]); chk("wrap_pc", o_pc, 32'h400);
    step(); chk("wrap_ins", o_instruction_D, 32'h11);

    // halt and drain
    i_halt_MC = 1; step(); i_halt_MC = 0;
    chk("halt_flag", {31'b0, o_halted}, 1); chk("halt_ins", o_instruction_D, 0);
    for (int k = 0; k < 6; k++) begin
      i_enable = 1'($urandom_range(0, 1)); i_stall_HD = 1'($urandom);
      step();
    end
    chk("halt_pc", o_pc, 32'h404);
    idle(); i_reset = 1; #1;
    chk("async_pc", o_pc, 0); chk("async_halt", {31'b0, o_halted}, 0);
    step(); idle();

    // write and fetch of the same word in one cycle
    step(); step();
    i_wr_en = 1; i_wr_addr = 2; i_wr_data = 32'hABCD; step();
    chk("old_word", o_instruction_D, 32'h33);
    rst_pulse(); step(); step(); step();
    chk("new_word", o_instruction_D, 32'hABCD);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      i_reset         = ($urandom_range(0, 99) == 0);
      i_enable        = ($urandom_range(0, 7) != 0);
      i_stall_HD      = ($urandom_range(0, 3) == 0);
      i_pc_src_D      = ($urandom_range(0, 5) == 0);
      i_jump_MC       = ($urandom_range(0, 7) == 0);
      i_jump_sel_MC   = 1'($urandom);
      i_halt_MC       = ($urandom_range(0, 60) == 0);
      i_wr_en         = ($urandom_range(0, 5) == 0);
      i_branch_addr_D = $urandom;
      i_jump_addr_D   = $urandom;
      i_rs_data_D     = $urandom;
      i_wr_addr       = A'($urandom);
      i_wr_data       = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
